lenet_scheduler: RTL and testbench
==================================

LENET_SCHEDULER -- requirements
Module: lenet_scheduler

Interface
REQ-001 Parameter FRAME_W, default 8: width of the frame-count fields.
REQ-002 clk  in  1  clock; every register updates on the rising edge.
REQ-003 srstn  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  single-cycle request to process frame_total frames.
REQ-005 frame_total  in  FRAME_W  number of frames per run, sampled when start is accepted.
REQ-006 abort  in  1  single-cycle request to cancel the run.
REQ-007 conv_done  in  1  single-cycle pulse from CONV: the current frame is fully written.
REQ-008 fc2_done  in  1  single-cycle pulse from FC: the current frame result is stored in sram f.
REQ-009 conv_start  out  1  single-cycle pulse that launches CONV on one frame.
REQ-010 conv_wsel  out  1  buffer CONV writes: 0 = sram c, 1 = sram d; held while CONV is busy.
REQ-011 fc_go  out  1  single-cycle pulse that launches FC; drives the FC conv_done input.
REQ-012 mem_sel  out  1  buffer FC reads: 1 = c, 0 = d; held while FC is busy.
REQ-013 busy  out  1  high from start acceptance until run end.
REQ-014 frame_done  out  1  single-cycle pulse, one per completed frame.
REQ-015 all_done  out  1  single-cycle pulse at run end.
REQ-016 fc_frame_cnt  out  FRAME_W  number of frames completed in the current run.
REQ-017 err  out  1  sticky protocol-error flag.

Function
REQ-018 Run FSM states are IDLE, RUN, DONE.
REQ-019 IDLE -> RUN when start=1 and frame_total!=0; frame_total is latched and the buffer-full flags, both pointers and both counters clear.
REQ-020 In IDLE, start with frame_total==0 is ignored; in RUN or DONE, every start is ignored.
REQ-021 Tracking state: buf_full[1:0], conv_busy, fc_busy, conv_wptr, fc_rptr, conv_issued count, fc_frame_cnt.
REQ-022 All issue decisions use registered state only; a decision made in cycle T produces its output pulse in cycle T+1.
REQ-023 conv_start is issued when all of the following hold: state RUN, !conv_busy, conv_issued<total, and !buf_full[conv_wptr].
REQ-024 On conv_start: conv_busy sets, conv_issued increments, and conv_wsel = conv_wptr.
REQ-025 On conv_done while conv_busy: conv_busy clears, buf_full[conv_wptr] sets, and conv_wptr toggles.
REQ-026 fc_go is issued when state is RUN, !fc_busy and buf_full[fc_rptr]; on fc_go, fc_busy sets and mem_sel = ~fc_rptr.
REQ-027 On fc2_done while fc_busy: fc_busy clears, buf_full[fc_rptr] clears, fc_rptr toggles, fc_frame_cnt increments, and frame_done pulses in the same cycle.
REQ-028 conv_done and fc2_done arriving in the same cycle are both applied.
REQ-029 A buffer freed by fc2_done in cycle T can be re-targeted by conv_start no earlier than cycle T+1.
REQ-030 When fc_frame_cnt reaches total, the FSM goes RUN -> DONE; all_done pulses in the DONE cycle, then the FSM goes DONE -> IDLE.
REQ-031 conv_done without conv_busy, or fc2_done without fc_busy, is ignored and sets err.
REQ-032 abort in any state forces IDLE on the next edge, clears all tracking state, and issues no pulse; err is retained.
REQ-033 Counters do not wrap; fc_frame_cnt holds its final value in IDLE until the next accepted start.

Reset
REQ-034 While srstn=0: state IDLE; all pulse outputs 0; busy, err, conv_wsel and fc_frame_cnt 0; mem_sel 1; all flags, pointers and counters 0.

Configuration
REQ-035 With LENET_PINGPONG_EN defined, CONV frame k+1 overlaps FC frame k through the c/d ping-pong.
REQ-036 With LENET_PINGPONG_EN undefined, operation is strictly serial:
- conv_start additionally requires !fc_busy and buf_full==0;
- the pointers stay at 0, so conv_wsel=0 and mem_sel=1 always.

Structure
REQ-037 A shared package lenet_pkg holds the run FSM state encoding, the buffer index constants (BUF_C=0, BUF_D=1) and the FRAME_W default.
REQ-038 A single sub-module, lenet_pp_tracker, holds buf_full, the two pointers and the busy flags; the run FSM stays in the top module.

Verification
REQ-039 Scenario: start with frame_total=1 at cycle 0 -> conv_start at cycle 1; conv_done at cycle 10 -> fc_go at 11 with mem_sel=1; fc2_done at 30 -> frame_done at 30, all_done at 31, busy=0 at 32.
REQ-040 Scenario, PINGPONG_EN, total=3: conv_done for frame 0 -> fc_go and conv_start (conv_wsel=1) in the same next cycle; the frame 2 conv_start is withheld until one cycle after the frame 0 fc2_done.
REQ-041 Scenario: conv_done and fc2_done asserted in the same cycle -> both applied, fc_go issued the next cycle on the other buffer, no err.
REQ-042 Scenario: abort mid-FC -> state IDLE and busy=0 next cycle, no further pulses, and a new start is accepted normally.
REQ-043 Scenario: spurious fc2_done in IDLE -> err=1 and held, no frame_done.
REQ-044 Scenario, PINGPONG_EN undefined, total=2: the second conv_start occurs only after the first fc2_done, and mem_sel stays 1 throughout.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet frame scheduler: run FSM encoding,
// ping-pong buffer indices and the default frame-count width.
package lenet_pkg;

  // Default width of the frame-count fields.
  localparam int FRAME_W_DEF = 8;

  // Buffer indices for the ping-pong pair (sram c / sram d).
  localparam logic BUF_C = 1'b0;
  localparam logic BUF_D = 1'b1;

  // Run-level FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_e;

endpackage

// File: rtl/lenet_pp_tracker.sv
// Ping-pong buffer tracker: buffer-full flags, CONV write pointer, FC read
// pointer and the CONV/FC busy flags. Pointers only toggle when the
// LENET_PINGPONG_EN macro is defined; otherwise both stay on sram c and the
// pipeline runs strictly serially.
module lenet_pp_tracker
  import lenet_pkg::*;
(
  input  logic       clk,
  input  logic       srstn,
  input  logic       clr,
  input  logic       conv_start,
  input  logic       fc_go,
  input  logic       conv_done,
  input  logic       fc2_done,
  output logic [1:0] buf_full,
  output logic       conv_wptr,
  output logic       fc_rptr,
  output logic       conv_busy,
  output logic       fc_busy,
  output logic       fc2_done_ok
);

  logic [1:0] buf_full_q, buf_full_d;
  logic       conv_wptr_q, conv_wptr_d;
  logic       fc_rptr_q, fc_rptr_d;
  logic       conv_busy_q, conv_busy_d;
  logic       fc_busy_q, fc_busy_d;
  logic       conv_done_ok;

  // Completion pulses only count when the matching engine was launched.
  assign conv_done_ok = conv_done & conv_busy_q;
  assign fc2_done_ok  = fc2_done & fc_busy_q;

  // Each buffer fills when CONV finishes writing it and drains when FC has
  // consumed it; a clear wins over both.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign buf_full_d[gi] = clr ? 1'b0 :
                              (conv_done_ok && (conv_wptr_q == 1'(gi))) ? 1'b1 :
                              (fc2_done_ok && (fc_rptr_q == 1'(gi))) ? 1'b0 :
                              buf_full_q[gi];
    end
  endgenerate

  // Busy flags and pointer advance for the two engines.
  always_comb begin
    conv_wptr_d = conv_wptr_q;
    fc_rptr_d   = fc_rptr_q;
    conv_busy_d = conv_busy_q;
    fc_busy_d   = fc_busy_q;
    if (conv_start) begin
      conv_busy_d = 1'b1;
    end
    if (conv_done_ok) begin
      conv_busy_d = 1'b0;
`ifdef LENET_PINGPONG_EN
      conv_wptr_d = ~conv_wptr_q;
`endif
    end
    if (fc_go) begin
      fc_busy_d = 1'b1;
    end
    if (fc2_done_ok) begin
      fc_busy_d = 1'b0;
`ifdef LENET_PINGPONG_EN
      fc_rptr_d = ~fc_rptr_q;
`endif
    end
    if (clr) begin
      conv_wptr_d = BUF_C;
      fc_rptr_d   = BUF_C;
      conv_busy_d = 1'b0;
      fc_busy_d   = 1'b0;
    end
  end

  // Tracking state registers.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      buf_full_q  <= 2'b00;
      conv_wptr_q <= BUF_C;
      fc_rptr_q   <= BUF_C;
      conv_busy_q <= 1'b0;
      fc_busy_q   <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      conv_wptr_q <= conv_wptr_d;
      fc_rptr_q   <= fc_rptr_d;
      conv_busy_q <= conv_busy_d;
      fc_busy_q   <= fc_busy_d;
    end
  end

  assign buf_full  = buf_full_q;
  assign conv_wptr = conv_wptr_q;
  assign fc_rptr   = fc_rptr_q;
  assign conv_busy = conv_busy_q;
  assign fc_busy   = fc_busy_q;

endmodule

// File: rtl/lenet_scheduler.sv
// LeNet frame scheduler: runs frame_total frames through CONV and FC,
// alternating the c/d buffers. Define LENET_PINGPONG_EN to overlap CONV of
// frame k+1 with FC of frame k; without it CONV and FC run strictly serially
// on sram c. Issue decisions look only at registered state and drive the
// launch pulses directly in the cycle they are taken.
module lenet_scheduler
  import lenet_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_total,
  input  logic               abort,
  input  logic               conv_done,
  input  logic               fc2_done,
  output logic               conv_start,
  output logic               conv_wsel,
  output logic               fc_go,
  output logic               mem_sel,
  output logic               busy,
  output logic               frame_done,
  output logic               all_done,
  output logic [FRAME_W-1:0] fc_frame_cnt,
  output logic               err
);

  localparam logic [FRAME_W-1:0] CNT_ONE = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] CNT_MAX = {FRAME_W{1'b1}};

  run_state_e         state_q, state_d;
  logic [FRAME_W-1:0] total_q, total_d;
  logic [FRAME_W-1:0] issued_q, issued_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  logic       start_ok;
  logic       trk_clr;
  logic       can_conv;
  logic       conv_issue;
  logic       fc_issue;
  logic [1:0] buf_full;
  logic       conv_wptr;
  logic       fc_rptr;
  logic       conv_busy;
  logic       fc_busy;
  logic       fc2_done_ok;

  // A run starts only from IDLE with a non-zero frame count; abort wins.
  assign start_ok = (state_q == ST_IDLE) && start && (frame_total != '0) && !abort;
  assign trk_clr  = abort || start_ok;

`ifdef LENET_PINGPONG_EN
  assign can_conv = !buf_full[conv_wptr];
`else
  assign can_conv = !fc_busy && (buf_full == 2'b00);
`endif

  assign conv_issue = (state_q == ST_RUN) && !abort && !conv_busy &&
                      (issued_q < total_q) && can_conv;
  assign fc_issue   = (state_q == ST_RUN) && !abort && !fc_busy && buf_full[fc_rptr];

  lenet_pp_tracker u_trk (
    .clk         (clk),
    .srstn       (srstn),
    .clr         (trk_clr),
    .conv_start  (conv_issue),
    .fc_go       (fc_issue),
    .conv_done   (conv_done),
    .fc2_done    (fc2_done),
    .buf_full    (buf_full),
    .conv_wptr   (conv_wptr),
    .fc_rptr     (fc_rptr),
    .conv_busy   (conv_busy),
    .fc_busy     (fc_busy),
    .fc2_done_ok (fc2_done_ok)
  );

  // Run FSM next state, frame counters and sticky protocol error.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    issued_d = issued_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (conv_done & ~conv_busy) | (fc2_done & ~fc_busy);
    if (abort) begin
      state_d  = ST_IDLE;
      issued_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_d  = ST_RUN;
            total_d  = frame_total;
            issued_d = '0;
            cnt_d    = '0;
          end
        end
        ST_RUN: begin
          if (conv_issue && (issued_q != CNT_MAX)) begin
            issued_d = issued_q + CNT_ONE;
          end
          if (fc2_done_ok && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (cnt_d == total_q) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Run FSM and counter registers.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q  <= ST_IDLE;
      total_q  <= '0;
      issued_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign conv_start   = conv_issue;
  assign fc_go        = fc_issue;
  assign conv_wsel    = conv_wptr;
  assign mem_sel      = ~fc_rptr;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = fc2_done_ok && !abort;
  assign all_done     = (state_q == ST_DONE) && !abort;
  assign fc_frame_cnt = cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_lenet_scheduler.sv
// Self-checking bench for lenet_scheduler. The bench plays the CONV and FC
// engines with random latencies; a frame-level reference model predicts each
// output pulse and pushes it into a scoreboard queue, and a monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_lenet_scheduler;

  logic       clk;
  logic       srstn;
  logic       start;
  logic [7:0] frame_total;
  logic       abort;
  logic       conv_done;
  logic       fc2_done;
  logic       conv_start;
  logic       conv_wsel;
  logic       fc_go;
  logic       mem_sel;
  logic       busy;
  logic       frame_done;
  logic       all_done;
  logic [7:0] fc_frame_cnt;
  logic       err;

  lenet_scheduler #(.FRAME_W(8)) dut (
    .clk          (clk),
    .srstn        (srstn),
    .start        (start),
    .frame_total  (frame_total),
    .abort        (abort),
    .conv_done    (conv_done),
    .fc2_done     (fc2_done),
    .conv_start   (conv_start),
    .conv_wsel    (conv_wsel),
    .fc_go        (fc_go),
    .mem_sel      (mem_sel),
    .busy         (busy),
    .frame_done   (frame_done),
    .all_done     (all_done),
    .fc_frame_cnt (fc_frame_cnt),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;
  bit mon_en  = 0;

  typedef struct {int cyc; bit v;} ev_t;
  typedef struct {int cyc; bit busy; bit err; int cnt;} lv_t;
  ev_t cs_q[$];
  ev_t fg_q[$];
  int  fd_q[$];
  int  ad_q[$];
  lv_t lv_q[$];

  // Frame-level reference model state.
  bit m_run, m_donep, m_err, m_cout, m_fout;
  int m_total, m_issued, m_conv, m_fcst, m_comp;
  int ctmr, ftmr;
  int lat_c_fix = -1;
  int lat_f_fix = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    m_run = 0; m_donep = 0; m_cout = 0; m_fout = 0;
    m_issued = 0; m_conv = 0; m_fcst = 0; m_comp = 0;
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit st, input int tot, input bit ab, input bit spur_fd);
    bit cd, fd, e_cs, e_fg, e_fd, free_ok;
    ev_t e;
    lv_t l;
    cd = m_cout && (ctmr == 0);
    fd = (m_fout && (ftmr == 0)) || spur_fd;
    start = st; frame_total = 8'(tot); abort = ab; conv_done = cd; fc2_done = fd;
`ifdef LENET_PINGPONG_EN
    // frame k uses buffer k%2, which frame k-2 must have released
    free_ok = (m_issued < 2) || (m_comp >= m_issued - 1);
    e.v = m_issued[0];
`else
    free_ok = (m_conv == m_comp) && !m_fout;
    e.v = 1'b0;
`endif
    e_cs = m_run && !ab && !m_cout && (m_issued < m_total) && free_ok;
    e.cyc = cyc;
    if (e_cs) cs_q.push_back(e);
    e_fg = m_run && !ab && !m_fout && (m_fcst < m_conv);
`ifdef LENET_PINGPONG_EN
    e.v = !m_fcst[0];
`else
    e.v = 1'b1;
`endif
    if (e_fg) fg_q.push_back(e);
    e_fd = fd && m_fout && !ab;
    if (e_fd) fd_q.push_back(cyc);
    if (m_donep && !ab) ad_q.push_back(cyc);
    l.cyc = cyc; l.busy = m_run || m_donep; l.err = m_err; l.cnt = m_comp;
    lv_q.push_back(l);

    @(posedge clk);
    #1;
    if ((cd && !m_cout) || (fd && !m_fout)) m_err = 1;
    if (ab) begin
      clear_model();
    end else if (m_donep) begin
      m_donep = 0;
    end else if (!m_run) begin
      if (st && (tot != 0)) begin
        clear_model();
        m_run = 1;
        m_total = tot;
      end
    end else begin
      if (cd && m_cout) begin m_cout = 0; m_conv++; end
      else if (m_cout) ctmr--;
      if (fd && m_fout) begin m_fout = 0; m_comp++; end
      else if (m_fout) ftmr--;
      if (e_cs) begin
        m_cout = 1; m_issued++;
        ctmr = (lat_c_fix >= 0) ? lat_c_fix : int'($urandom_range(0, 5));
      end
      if (e_fg) begin
        m_fout = 1; m_fcst++;
        ftmr = (lat_f_fix >= 0) ? lat_f_fix : int'($urandom_range(0, 7));
      end
      if (m_comp == m_total) begin m_run = 0; m_donep = 1; end
    end
    start = 0; abort = 0; conv_done = 0; fc2_done = 0;
  endtask

  // Step until the model returns to idle, bounded by a cycle budget.
  task automatic run_to_idle(input int budget, input int abort_at);
    int k;
    k = 0;
    while ((m_run || m_donep) && (k < budget)) begin
      step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)), (k == abort_at), 0);
      k++;
    end
    if (m_run || m_donep) begin
      n_total++; n_bad++;
      $display("FAIL run_timeout cyc=%0d got=running want=idle", cyc);
      clear_model();
    end
  endtask

  // Scoreboard monitor: pops expectations as the DUT presents outputs.
  always @(negedge clk) begin : monitor
    ev_t e;
    lv_t l;
    bit  want;
    if (mon_en) begin
      want = (cs_q.size() != 0) && (cs_q[0].cyc == cyc);
      chk("conv_start", conv_start, want);
      if (want) begin
        e = cs_q.pop_front();
        if (conv_start) chk("conv_wsel", conv_wsel, e.v);
      end
      want = (fg_q.size() != 0) && (fg_q[0].cyc == cyc);
      chk("fc_go", fc_go, want);
      if (want) begin
        e = fg_q.pop_front();
        if (fc_go) chk("mem_sel", mem_sel, e.v);
      end
      want = (fd_q.size() != 0) && (fd_q[0] == cyc);
      chk("frame_done", frame_done, want);
      if (want) begin
        void'(fd_q.pop_front());
        $display("frame_done cyc=%0d cnt_before=%0d", cyc, fc_frame_cnt);
      end
      want = (ad_q.size() != 0) && (ad_q[0] == cyc);
      chk("all_done", all_done, want);
      if (want) begin
        void'(ad_q.pop_front());
        $display("all_done cyc=%0d", cyc);
      end
      if ((lv_q.size() != 0) && (lv_q[0].cyc == cyc)) begin
        l = lv_q.pop_front();
        chk("busy", busy, l.busy);
        chk("err", err, l.err);
        chk("fc_frame_cnt", fc_frame_cnt, l.cnt);
      end else begin
        n_total++; n_bad++;
        $display("FAIL level_sync cyc=%0d got=no_expectation want=one", cyc);
      end
`ifndef LENET_PINGPONG_EN
      chk("serial_mem_sel", mem_sel, 1);
      chk("serial_conv_wsel", conv_wsel, 0);
`endif
    end
  end

  initial begin
    srstn = 0; start = 0; frame_total = 0; abort = 0; conv_done = 0; fc2_done = 0;
    m_err = 0; clear_model(); ctmr = 0; ftmr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_fc_go", fc_go, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_conv_wsel", conv_wsel, 0);
    chk("rst_mem_sel", mem_sel, 1);
    chk("rst_cnt", fc_frame_cnt, 0);
    srstn = 1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Single frame with fixed engine latencies.
    lat_c_fix = 8; lat_f_fix = 18;
    step(1, 1, 0, 0);
    run_to_idle(200, -1);
    step(0, 0, 0, 0);
    $display("run single-frame done cyc=%0d", cyc);

    // Zero-frame start is ignored.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Equal latencies make conv_done and fc2_done coincide.
    lat_c_fix = 3; lat_f_fix = 3;
    step(1, 3, 0, 0);
    run_to_idle(200, -1);
    $display("run coincident total=3 done cyc=%0d", cyc);

    // Randomized runs, some aborted part way.
    lat_c_fix = -1; lat_f_fix = -1;
    for (int r = 0; r < 25; r++) begin
      int tot;
      int abort_at;
      tot = int'($urandom_range(1, 6));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      step(1, tot, 0, 0);
      $display("run %0d total=%0d abort_at=%0d cyc=%0d", r, tot, abort_at, cyc);
      run_to_idle(400, abort_at);
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0);
    end

    // Abort while FC is busy, then a fresh run.
    step(1, 3, 0, 0);
    for (int k = 0; k < 100 && !m_fout && m_run; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    $display("abort mid-fc cyc=%0d", cyc);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 2, 0, 0);
    run_to_idle(200, -1);

    // Spurious fc2_done in idle sets the sticky error.
    step(0, 0, 0, 1);
    $display("spurious fc2_done cyc=%0d", cyc);
    repeat (3) step(0, 0, 0, 0);
    mon_en = 0;

    n_total++;
    if ((cs_q.size() + fg_q.size() + fd_q.size() + ad_q.size()) != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations got=%0d want=0",
               cs_q.size() + fg_q.size() + fd_q.size() + ad_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
